chess_clock_multi: RTL and testbench

- Parametrised successor to the fixed two-player game timer used by the chess engine.
- Holds per-player countdown times as BCD digits (mins, tens-sec, units-sec) and generates a 1 Hz tick from the system clock.
- Decrements only the active player and supports a Fischer increment on move completion.
- Rotates turn among PLAYERS, flags timeout, and exposes packed BCD per player for the seven-segment decoders in the engine.

---
 rtl/chess_clock_pkg.sv | 15 +
 rtl/bcd_time_step.sv | 29 ++
 rtl/chess_clock_multi.sv | 68 ++++++
 tb/tb_chess_clock_multi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: shared state, BCD time types and limits for the chess clock
package chess_clock_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, TIMEOUT} state_t;
    typedef logic [3:0] bcd_t;
    typedef struct packed {
        bcd_t mins;
        bcd_t tens;
        bcd_t units;
    } bcd_time_t;
    localparam bcd_t MAX_MINS = 4'd9;
    localparam bcd_t MAX_TENS = 4'd5;
    function automatic bcd_time_t to_bcd(int m, int s);
        return {bcd_t'(m), bcd_t'(s / 10), bcd_t'(s % 10)};
    endfunction
endpackage

// File: rtl/bcd_time_step.sv
// bcd_time_step: one-second BCD decrement then saturating increment, with zero detect
module bcd_time_step
    import chess_clock_pkg::*;
(
    input  logic [11:0] cur,
    input  logic        dec,
    input  logic [3:0]  inc,
    output logic [11:0] nxt,
    output logic        zero
);
    bcd_time_t t, d;
    logic [4:0] u, m;
    logic [3:0] tn;
    logic cu, ct;
    assign t = cur;
    assign d = !dec ? t :
               t.units != 4'd0 ? {t.mins, t.tens, t.units - 4'd1} :
               t.tens != 4'd0 ? {t.mins, t.tens - 4'd1, 4'd9} :
               t.mins != 4'd0 ? {t.mins - 4'd1, MAX_TENS, 4'd9} : t;
    assign zero = dec && d == '0;
    assign u = {1'b0, d.units} + {1'b0, inc};
    assign cu = u > 5'd9;
    assign tn = d.tens + {3'b0, cu};
    assign ct = tn > MAX_TENS;
    assign m = {1'b0, d.mins} + {4'b0, ct};
    assign nxt = zero ? '0 :
                 m > {1'b0, MAX_MINS} ? {MAX_MINS, MAX_TENS, 4'd9} :
                 {m[3:0], ct ? 4'd0 : tn, cu ? 4'(u - 5'd10) : u[3:0]};
endmodule

// File: rtl/chess_clock_multi.sv
// chess_clock_multi: multi-player BCD countdown game clock with Fischer increment
module chess_clock_multi
    import chess_clock_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50000000,
    parameter int PLAYERS       = 2,
    parameter int INIT_MINS     = 5,
    parameter int INIT_SECS     = 0,
    parameter int INCREMENT_SEC = 0
) (
    input  logic                   clock,
    input  logic                   globalReset,
    input  logic                   timerEnable,
    input  logic                   play,
    input  logic                   turnEnd,
    input  logic                   loadTime,
    output logic [1:0]             activePlayer,
    output logic [4*PLAYERS-1:0]   mins,
    output logic [4*PLAYERS-1:0]   tensSec,
    output logic [4*PLAYERS-1:0]   unitsSec,
    output logic [PLAYERS-1:0]     timeout,
    output logic                   running
);
    localparam int PW = $clog2(CLOCK_FREQ);
    localparam int AW = PLAYERS > 2 ? 2 : 1;
    localparam bcd_time_t INIT = to_bcd(INIT_MINS, INIT_SECS);
    state_t state, state_n;
    logic [PW-1:0] presc;
    bcd_time_t times [PLAYERS];
    logic [11:0] nxt;
    logic go, cnt, tick, turn_ok, inc_on, zero;
    assign go = timerEnable && play;
    assign cnt = state == RUN && go;
    assign tick = cnt && presc == PW'(CLOCK_FREQ - 1);
    assign turn_ok = turnEnd && timerEnable && state != TIMEOUT;
    assign inc_on = turn_ok && state == RUN;
    bcd_time_step u_step (
        .cur (times[activePlayer[AW-1:0]]),
        .dec (tick),
        .inc (inc_on ? bcd_t'(INCREMENT_SEC) : 4'd0),
        .nxt (nxt),
        .zero(zero)
    );
    always_comb
        state_n = zero ? TIMEOUT : state == TIMEOUT ? TIMEOUT : go ? RUN : state == IDLE ? IDLE : PAUSE;
    always_ff @(posedge clock) begin
        if (!globalReset || loadTime) begin
            state <= IDLE;
            presc <= '0;
            activePlayer <= '0;
            timeout <= '0;
            running <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) times[p] <= INIT;
        end else begin
            state <= state_n;
            running <= state_n == RUN;
            if (cnt) presc <= tick ? '0 : presc + PW'(1);
            if (tick || inc_on) times[activePlayer[AW-1:0]] <= nxt;
            if (zero) timeout <= timeout | (PLAYERS'(1) << activePlayer);
            if (turn_ok && !zero) activePlayer <= activePlayer == 2'(PLAYERS - 1) ? 2'd0 : activePlayer + 2'd1;
        end
    end
    for (genvar g = 0; g < PLAYERS; g++) begin : g_out
        assign mins[4*g +: 4] = times[g].mins;
        assign tensSec[4*g +: 4] = times[g].tens;
        assign unitsSec[4*g +: 4] = times[g].units;
    end
endmodule

// File: tb/tb_chess_clock_multi.sv
// tb_chess_clock_multi: directed table, hand sequences and random run against a seconds-level model
module tb_chess_clock_multi;
    logic clock = 1'b0;
    logic rst_n, en, play, turn, load;
    always #5 clock = ~clock;

    logic [1:0] a_act, b_act, c_act;
    logic [7:0] a_min, a_ten, a_uni;
    logic [11:0] b_min, b_ten, b_uni;
    logic [15:0] c_min, c_ten, c_uni;
    logic [1:0] a_to;
    logic [2:0] b_to;
    logic [3:0] c_to;
    logic a_run, b_run, c_run;

    chess_clock_multi #(.CLOCK_FREQ(4), .PLAYERS(2), .INIT_MINS(0), .INIT_SECS(3), .INCREMENT_SEC(2)) dut (
        .clock(clock), .globalReset(rst_n), .timerEnable(en), .play(play), .turnEnd(turn), .loadTime(load),
        .activePlayer(a_act), .mins(a_min), .tensSec(a_ten), .unitsSec(a_uni), .timeout(a_to), .running(a_run));
    chess_clock_multi #(.CLOCK_FREQ(4), .PLAYERS(3), .INIT_MINS(9), .INIT_SECS(58), .INCREMENT_SEC(2)) dut_b (
        .clock(clock), .globalReset(rst_n), .timerEnable(en), .play(play), .turnEnd(turn), .loadTime(load),
        .activePlayer(b_act), .mins(b_min), .tensSec(b_ten), .unitsSec(b_uni), .timeout(b_to), .running(b_run));
    chess_clock_multi #(.CLOCK_FREQ(2), .PLAYERS(4), .INIT_MINS(1), .INIT_SECS(0), .INCREMENT_SEC(0)) dut_c (
        .clock(clock), .globalReset(rst_n), .timerEnable(en), .play(play), .turnEnd(turn), .loadTime(load),
        .activePlayer(c_act), .mins(c_min), .tensSec(c_ten), .unitsSec(c_uni), .timeout(c_to), .running(c_run));

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_TO = 3;
    int cf_f[3] = '{4, 4, 2};
    int cf_n[3] = '{2, 3, 4};
    int cf_init[3] = '{3, 598, 60};
    int cf_inc[3] = '{2, 2, 0};
    int m_secs[3][4];
    int m_st[3], m_presc[3], m_a[3];
    logic [3:0] m_to[3];
    bit m_run[3];
    int total = 0, bad = 0;

    typedef struct {
        int n, r, e, p, t, l;
        int act, t0, t1, to, run;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [11:0] bcd12(int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int dut_t(int k, int p);
        case (k)
            0: return int'({a_min[4*p +: 4], a_ten[4*p +: 4], a_uni[4*p +: 4]});
            1: return int'({b_min[4*p +: 4], b_ten[4*p +: 4], b_uni[4*p +: 4]});
            default: return int'({c_min[4*p +: 4], c_ten[4*p +: 4], c_uni[4*p +: 4]});
        endcase
    endfunction

    function automatic int dut_act(int k);
        return k == 0 ? int'(a_act) : k == 1 ? int'(b_act) : int'(c_act);
    endfunction

    function automatic logic [3:0] dut_to(int k);
        return k == 0 ? {2'b0, a_to} : k == 1 ? {1'b0, b_to} : c_to;
    endfunction

    function automatic bit dut_run(int k);
        return k == 0 ? a_run : k == 1 ? b_run : c_run;
    endfunction

    task automatic model_step(input int k);
        int a, s;
        bit go, cnt, tk, tv, inc_on, hit;
        if (!rst_n || load) begin
            m_st[k] = S_IDLE; m_presc[k] = 0; m_a[k] = 0; m_to[k] = '0; m_run[k] = 0;
            for (int p = 0; p < 4; p++) m_secs[k][p] = cf_init[k];
        end else begin
            a = m_a[k];
            go = en && play;
            cnt = m_st[k] == S_RUN && go;
            tk = cnt && m_presc[k] == cf_f[k] - 1;
            tv = turn && en && m_st[k] != S_TO;
            inc_on = tv && m_st[k] == S_RUN;
            hit = tk && m_secs[k][a] <= 1;
            s = m_secs[k][a] - (tk ? 1 : 0) + (inc_on ? cf_inc[k] : 0);
            if (tk || inc_on) m_secs[k][a] = hit ? 0 : (s > 599 ? 599 : s);
            if (cnt) m_presc[k] = tk ? 0 : m_presc[k] + 1;
            if (hit) m_to[k][a] = 1'b1;
            m_st[k] = hit ? S_TO : m_st[k] == S_TO ? S_TO : go ? S_RUN : m_st[k] == S_IDLE ? S_IDLE : S_PAUSE;
            if (tv && !hit) m_a[k] = (a + 1) % cf_n[k];
            m_run[k] = m_st[k] == S_RUN;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic check_model(input int k);
        bit ok;
        ok = dut_act(k) == m_a[k] && dut_to(k) == m_to[k] && dut_run(k) == m_run[k];
        for (int p = 0; p < cf_n[k]; p++) if (dut_t(k, p) != int'(bcd12(m_secs[k][p]))) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL model%0d @%0t: act=%0d want %0d to=%b want %b run=%b want %b p0=%h want %h p1=%h want %h",
                     k, $time, dut_act(k), m_a[k], dut_to(k), m_to[k], dut_run(k), m_run[k],
                     dut_t(k, 0), bcd12(m_secs[k][0]), dut_t(k, 1), bcd12(m_secs[k][1]));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; play = 1'b1; turn = 1'b0; load = 1'b0;
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 1});
        tbl.push_back('{4, 1, 1, 1, 0, 0, 0, 'h002, 'h003, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 'h004, 'h003, 0, 1});
        tbl.push_back('{3, 1, 1, 1, 0, 0, 1, 'h004, 'h002, 0, 1});
        tbl.push_back('{8, 1, 1, 1, 0, 0, 1, 'h004, 'h000, 2, 0});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 'h004, 'h000, 2, 0});
        tbl.push_back('{5, 1, 1, 1, 0, 0, 1, 'h004, 'h000, 2, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 1});
        tbl.push_back('{2, 1, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 1});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{9, 1, 1, 0, 0, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 'h002, 'h003, 0, 1});
        tbl.push_back('{3, 1, 1, 1, 0, 0, 0, 'h002, 'h003, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 'h003, 'h003, 0, 1});
        tbl.push_back('{8, 1, 1, 1, 0, 0, 1, 'h003, 'h001, 0, 1});
        tbl.push_back('{3, 1, 1, 1, 0, 0, 1, 'h003, 'h001, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 'h003, 'h000, 2, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{6, 1, 1, 1, 0, 0, 0, 'h002, 'h003, 0, 1});
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{3, 1, 0, 1, 0, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 'h003, 'h003, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 'h003, 'h003, 0, 1});
        foreach (tbl[i]) begin
            rst_n = tbl[i].r != 0; en = tbl[i].e != 0; play = tbl[i].p != 0;
            turn = tbl[i].t != 0; load = tbl[i].l != 0;
            repeat (tbl[i].n) cycle();
            chk($sformatf("row%0d act", i), int'(a_act), tbl[i].act);
            chk($sformatf("row%0d p0", i), dut_t(0, 0), tbl[i].t0);
            chk($sformatf("row%0d p1", i), dut_t(0, 1), tbl[i].t1);
            chk($sformatf("row%0d timeout", i), int'(a_to), tbl[i].to);
            chk($sformatf("row%0d running", i), int'(a_run), tbl[i].run);
        end
        rst_n = 1'b0; en = 1'b1; play = 1'b1; turn = 1'b0; load = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        turn = 1'b1;
        cycle();
        chk("b sat p0", dut_t(1, 0), 'h959);
        chk("b act1", int'(b_act), 1);
        chk("c p0 no inc", dut_t(2, 0), 'h100);
        cycle();
        chk("c tens borrow p1", dut_t(2, 1), 'h059);
        chk("b sat p1", dut_t(1, 1), 'h959);
        chk("c act2", int'(c_act), 2);
        cycle();
        chk("b act wrap", int'(b_act), 0);
        chk("b p2", dut_t(1, 2), 'h959);
        chk("c act3", int'(c_act), 3);
        cycle();
        chk("c act wrap", int'(c_act), 0);
        chk("c p3", dut_t(2, 3), 'h059);
        chk("b sat tick+inc", dut_t(1, 0), 'h959);
        for (int i = 0; i < 3000; i++) begin
            rst_n = i == 0 ? 1'b0 : $urandom_range(63) != 0;
            en = $urandom_range(9) != 0;
            play = $urandom_range(6) != 0;
            turn = $urandom_range(5) == 0;
            load = $urandom_range(49) == 0;
            cycle();
            for (int k = 0; k < 3; k++) check_model(k);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
